board_palette_map: RTL
======================

BOARD_PALETTE_MAP -- requirements
Module: board_palette_map

Interface
REQ-001 SHALL have parameter CELLS, default 9; meaning: number of board cells (supported range 1..64).
REQ-002 SHALL have parameter BLINK_DIV, default 12_500_000; meaning: pixclk cycles per blink half-period (supported range 2..2^26).
REQ-003 SHALL have parameter CHG_HOLD, default 4; meaning: blink half-periods a newly placed piece stays highlighted (supported range 1..15).
REQ-004 pixclk  input  1  sole clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 board  input  2*CELLS  cell i in bits [2i+1:2i]: 00 empty, 01 O, 11 X, 10 invalid.
REQ-007 win_mask  input  CELLS  bit i set = cell i belongs to the winning line.
REQ-008 red, green, blue  output  CELLS each  registered per-cell colour bits; bit i drives cell i.
REQ-009 blink_phase  output  1  current blink half-period, registered.
REQ-010 err  output  1  sticky invalid-code flag (see Configuration).

Function
REQ-011 Stage 1 SHALL register board and win_mask every cycle into board_q and win_q.
REQ-012 Stage 2 SHALL register the colours; latency from board or win_mask change to red/green/blue is exactly 2 cycles.
REQ-013 Base colours: O gives green=1; X gives red=1; empty gives all 0; invalid gives all 0.
REQ-014 Blink counter runs 0..BLINK_DIV-1, wraps to 0; blink_phase toggles on the cycle the counter wraps.
REQ-015 When win_q[i]=1, cell i is non-empty and valid, and blink_phase=1, red/green/blue[i] SHALL all be 1 (white), overriding every other rule.
REQ-016 When win_q[i]=1, cell i is non-empty and valid, and blink_phase=0, the base colour SHALL be shown.
REQ-017 win_q[i]=1 on an empty or invalid cell SHALL be ignored.
REQ-018 Each cell has a 4-bit hold counter. An empty-to-valid-non-empty transition of board_q[i] versus its previous value SHALL load CHG_HOLD.
REQ-019 A hold counter SHALL decrement by 1 on each blink wrap while nonzero, and saturate at 0.
REQ-020 A load and a blink wrap in the same cycle: the load wins.
REQ-021 A non-empty-to-empty transition (new game) SHALL clear that cell's hold counter in the same cycle.
REQ-022 While hold[i]!=0 and REQ-015 is inactive, blue[i]=1 is OR-ed onto the base colour.
REQ-023 A non-empty-to-different-non-empty change (O to X) SHALL NOT load the hold counter.
REQ-024 The first cycle after reset SHALL be treated as a previous board of all-empty.

Reset
REQ-025 rst_n=0 SHALL asynchronously clear: red, green, blue, blink_phase, err, the blink counter, all hold counters, board_q, win_q and the previous-board register.
REQ-026 Reset asserted mid-blink or mid-hold SHALL abandon that state; after release the counting restarts from 0.
REQ-027 Outputs after release SHALL follow REQ-012 latency; no output glitch beyond 2 cycles after release.

Configuration
REQ-028 Macro BOARD_PALETTE_INVALID_FLAG_EN is the single compile-time option.
REQ-029 Defined: err SHALL go to 1 two cycles after any cell presents code 10, and stay 1 until reset.
REQ-030 Undefined: err SHALL be tied to 0, code 10 is displayed as empty, and no flag logic is synthesised.

Verification
REQ-031 CELLS=9, BLINK_DIV=4: reset, then board=18'h00001 (cell 0 = O) -> green[0]=1 after exactly 2 cycles, with blue[0]=1 for 4 blink half-periods (16 cycles), then blue[0]=0.
REQ-032 BLINK_DIV=4: cells 0, 4 and 8 = X, win_mask=9'b100010001 -> red/green/blue bits 0, 4 and 8 alternate between all-1 and red-only every 4 cycles.
REQ-033 Board full, then board=0 -> all colours 0 two cycles later and all hold counters read 0 immediately.
REQ-034 With BOARD_PALETTE_INVALID_FLAG_EN defined: cell 3 = 2'b10 for 1 cycle, then 00 -> err=1 from cycle 2 onward and it persists; rst_n pulse clears it. Without the macro -> err stays 0.
REQ-035 rst_n asserted while the hold counter is 2 and blink_phase=1 -> all outputs 0 asynchronously; after release blink_phase is first seen toggling 4 cycles later.

Source files
------------

// File: rtl/board_palette_map.sv
// Per-cell colour mapper for a game board: base colours, blinking winning line, blue "new piece" highlight.
// Compile-time option BOARD_PALETTE_INVALID_FLAG_EN adds a sticky err flag for the invalid cell code 2'b10.
module board_palette_map #(
  parameter int CELLS     = 9,
  parameter int BLINK_DIV = 12_500_000,
  parameter int CHG_HOLD  = 4
) (
  input  logic                 pixclk,
  input  logic                 rst_n,
  input  logic [2*CELLS-1:0]   board,
  input  logic [CELLS-1:0]     win_mask,
  output logic [CELLS-1:0]     red,
  output logic [CELLS-1:0]     green,
  output logic [CELLS-1:0]     blue,
  output logic                 blink_phase,
  output logic                 err
);

  localparam int              CNT_W     = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [3:0]      HOLD_LOAD = 4'(CHG_HOLD);

  logic [2*CELLS-1:0] board_q;
  logic [2*CELLS-1:0] prev_q;
  logic [CELLS-1:0]   win_q;
  logic [CNT_W-1:0]   blink_cnt;
  logic               blink_wrap;
  logic [CELLS-1:0]   red_d;
  logic [CELLS-1:0]   green_d;
  logic [CELLS-1:0]   blue_d;

  // Stage 1: input capture; prev_q holds the board_q of the previous cycle for transition detection.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      board_q <= '0;
      prev_q  <= '0;
      win_q   <= '0;
    end else begin
      board_q <= board;
      prev_q  <= board_q;
      win_q   <= win_mask;
    end
  end

  assign blink_wrap = (blink_cnt == CNT_LAST);

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_wrap) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < CELLS; g++) begin : g_cell
    logic [1:0] cur;
    logic [1:0] prv;
    logic       is_o;
    logic       is_x;
    logic       hold_ld;
    logic       hold_clr;
    logic       white;
    logic [3:0] hold;
    logic [3:0] hold_eff;

    assign cur      = board_q[2*g +: 2];
    assign prv      = prev_q[2*g +: 2];
    assign is_o     = (cur == 2'b01);
    assign is_x     = (cur == 2'b11);
    assign hold_ld  = (prv == 2'b00) && (is_o || is_x);
    assign hold_clr = (prv != 2'b00) && (cur == 2'b00);

    // The colour stage sees the post-load/clear value so blue appears with the piece and vanishes with it.
    assign hold_eff = hold_clr ? 4'd0 : (hold_ld ? HOLD_LOAD : hold);

    always_ff @(posedge pixclk or negedge rst_n) begin
      if (!rst_n)                          hold <= 4'd0;
      else if (hold_clr)                   hold <= 4'd0;
      else if (hold_ld)                    hold <= HOLD_LOAD;
      else if (blink_wrap && hold != 4'd0) hold <= hold - 4'd1;
    end

    assign white      = win_q[g] && (is_o || is_x) && blink_phase;
    assign red_d[g]   = white | is_x;
    assign green_d[g] = white | is_o;
    assign blue_d[g]  = white | (hold_eff != 4'd0);
  end

  // Stage 2: registered colour outputs.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= red_d;
      green <= green_d;
      blue  <= blue_d;
    end
  end

`ifdef BOARD_PALETTE_INVALID_FLAG_EN
  logic [CELLS-1:0] bad;
  logic             err_q;

  for (genvar b = 0; b < CELLS; b++) begin : g_bad
    assign bad[b] = (board_q[2*b +: 2] == 2'b10);
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | (|bad);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
